// File: rtl/product_bcd_converter.sv
// product_bcd_converter
// Sequential binary-to-BCD converter for a product of up to 6 bits (0..63).
// It uses a one-bit-per-cycle shift-and-add-3 (double-dabble) engine with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   p holds a product to convert
//   in_ready  out  converter can accept a product (IDLE, after reset release)
//   p         in   unsigned product, IN_W bits
//   out_valid out  bcd_tens/bcd_ones hold a finished result (DONE)
//   out_ready in   consumer takes the result
//   bcd_tens  out  tens digit 0..6
//   bcd_ones  out  ones digit 0..9
//   busy      out  high in SHIFT and DONE
//   seg_tens  out  7-seg gfedcba of tens (only with PRODUCT_BCD_SEVENSEG_EN)
//   seg_ones  out  7-seg gfedcba of ones (only with PRODUCT_BCD_SEVENSEG_EN)
//
// Optional feature macro: PRODUCT_BCD_SEVENSEG_EN
module product_bcd_converter #(
  parameter int IN_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] p,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      bcd_tens,
  output logic [3:0]      bcd_ones,
  output logic            busy
`ifdef PRODUCT_BCD_SEVENSEG_EN
  ,
  output logic [6:0]      seg_tens,
  output logic [6:0]      seg_ones
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_live;
  logic [IN_W-1:0]   r_bin;
  logic [7:0]        r_scr;
  logic [2:0]        r_cnt;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;
  logic              w_accept;
  logic              w_last;
  logic [3:0]        w_tens_adj;
  logic [3:0]        w_ones_adj;
  logic [7:0]        w_scr_sh;

`ifdef PRODUCT_BCD_SEVENSEG_EN
  logic [6:0]        r_seg_tens;
  logic [6:0]        r_seg_ones;

  // Active-high gfedcba segment pattern for one BCD digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction
`endif

  // Next-state decode and handshake qualifiers
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_live keeps the block from accepting before the first post-reset edge
        if (r_live && in_valid) begin
          w_state_nx = S_SHIFT;
          w_accept   = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 3'd1) begin
          w_state_nx = S_DONE;
          w_last     = 1'b1;
        end else begin
          w_state_nx = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Add-3 correction on both nibbles, then shift the binary MSB into the scratch
  always_comb begin
    if (r_scr[7:4] >= 4'd5) begin
      w_tens_adj = r_scr[7:4] + 4'd3;
    end else begin
      w_tens_adj = r_scr[7:4];
    end
    if (r_scr[3:0] >= 4'd5) begin
      w_ones_adj = r_scr[3:0] + 4'd3;
    end else begin
      w_ones_adj = r_scr[3:0];
    end
    // The tens nibble stays below 8 for IN_W <= 6, so its MSB is dropped
    w_scr_sh = {w_tens_adj[2:0], w_ones_adj, r_bin[IN_W-1]};
  end

  // State register and post-reset ready arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_live  <= 1'b1;
    end
  end

  // Double-dabble datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_scr  <= 8'd0;
      r_cnt  <= 3'd0;
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (w_accept) begin
      r_bin <= p;
      r_scr <= 8'd0;
      r_cnt <= 3'(IN_W);
    end else if (r_state == S_SHIFT) begin
      r_bin <= r_bin << 1;
      r_scr <= w_scr_sh;
      r_cnt <= r_cnt - 3'd1;
      if (w_last) begin
        r_tens <= w_scr_sh[7:4];
        r_ones <= w_scr_sh[3:0];
      end
    end
  end

`ifdef PRODUCT_BCD_SEVENSEG_EN
  // Segment patterns follow the BCD result on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_tens <= 7'h3F;
      r_seg_ones <= 7'h3F;
    end else if (w_last) begin
      r_seg_tens <= seg7(w_scr_sh[7:4]);
      r_seg_ones <= seg7(w_scr_sh[3:0]);
    end
  end

  assign seg_tens = r_seg_tens;
  assign seg_ones = r_seg_ones;
`endif

  assign in_ready  = (r_state == S_IDLE) && r_live;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign bcd_tens  = r_tens;
  assign bcd_ones  = r_ones;

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

  localparam int IN_W = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [IN_W-1:0] p = '0;
  logic            in_ready;
  logic            out_valid;
  logic [3:0]      bcd_tens;
  logic [3:0]      bcd_ones;
  logic            busy;
`ifdef PRODUCT_BCD_SEVENSEG_EN
  logic [6:0]      seg_tens;
  logic [6:0]      seg_ones;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q[$];

  product_bcd_converter #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .busy      (busy)
`ifdef PRODUCT_BCD_SEVENSEG_EN
    ,
    .seg_tens  (seg_tens),
    .seg_ones  (seg_ones)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] bcd_model(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

`ifdef PRODUCT_BCD_SEVENSEG_EN
  function automatic logic [6:0] seg_model(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction
`endif

  // One conversion: accept, measure latency, compare digits, optional backpressure, consume
  task automatic do_conv(input int v, input int hold);
    int n;
    logic [7:0] expv;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    p = IN_W'(v);
    @(posedge clk);
    sb_q.push_back(bcd_model(v));
    @(negedge clk);
    in_valid = 1'b0;
    p = '0;
    chk("shift_flags", {5'd0, busy, in_ready, out_valid}, 8'b0000_0100);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 8'(n), 8'(IN_W));
    expv = sb_q.pop_front();
    chk("digits", {bcd_tens, bcd_ones}, expv);
`ifdef PRODUCT_BCD_SEVENSEG_EN
    chk("seg_tens", {1'b0, seg_tens}, {1'b0, seg_model(expv[7:4])});
    chk("seg_ones", {1'b0, seg_ones}, {1'b0, seg_model(expv[3:0])});
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 0);
      p = IN_W'(25);
      @(negedge clk);
      chk("hold_digits", {bcd_tens, bcd_ones}, expv);
      chk("hold_flags", {5'd0, busy, in_ready, out_valid}, 8'b0000_0101);
    end
    in_valid = 1'b0;
    p = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consume_flags", {5'd0, busy, in_ready, out_valid}, 8'b0000_0010);
  endtask

  initial begin
    int mult_a [9];
    int mult_b [9];
    mult_a = '{0, 1, 2, 3, 4, 5, 6, 7, 7};
    mult_b = '{0, 7, 3, 3, 5, 6, 6, 6, 7};

    // Reset state
    #1;
    chk("rst_flags", {5'd0, busy, in_ready, out_valid}, 8'd0);
    chk("rst_digits", {bcd_tens, bcd_ones}, 8'd0);
`ifdef PRODUCT_BCD_SEVENSEG_EN
    chk("rst_seg", {seg_tens[3:0], seg_ones[3:0]}, 8'hFF);
    chk("rst_seg_hi", {1'b0, seg_tens[6:4], 1'b0, seg_ones[6:4]}, 8'h33);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {5'd0, busy, in_ready, out_valid}, 8'b0000_0010);

    // Basic and range limits
    do_conv(49, 0);
    do_conv(0, 0);
    do_conv(63, 0);

    // Backpressure with an ignored p=25, then a real p=25
    do_conv(9, 5);
    do_conv(25, 0);

    // Reset in flight
    in_valid = 1'b1;
    p = IN_W'(36);
    @(posedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_flags", {5'd0, busy, in_ready, out_valid}, 8'd0);
    chk("inflight_rst_digits", {bcd_tens, bcd_ones}, 8'd0);
`ifdef PRODUCT_BCD_SEVENSEG_EN
    chk("inflight_rst_seg_t", {1'b0, seg_tens}, 8'h3F);
    chk("inflight_rst_seg_o", {1'b0, seg_ones}, 8'h3F);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("inflight_release_ready", {7'd0, in_ready}, 8'd1);
    do_conv(36, 0);

    // Exhaustive sweep
    for (int i = 0; i < 64; i++) begin
      do_conv(i, 0);
    end

    // Multiplier bench vectors
    for (int i = 0; i < 9; i++) begin
      do_conv(mult_a[i] * mult_b[i], 0);
    end

    chk("scoreboard_empty", 8'(sb_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 3×3 `multiplier`. It takes the 6-bit product `P` (0–63) and converts it to two BCD digits (tens, ones) using a one-bit-per-cycle shift-and-add-3 (double-dabble) engine. It uses a valid/ready handshake on both sides so it can feed a display or logging stage.

## Interface
Parameters:
- `IN_W`, default 6: product width. Legal range is 1–6, so the result always fits in two BCD digits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  `p` holds a product to convert.
- `in_ready`  out  1  converter can accept a product.
- `p`  in  IN_W  unsigned binary product, connected to multiplier `P`.
- `out_valid`  out  1  `bcd_tens`/`bcd_ones` hold a finished result.
- `out_ready`  in  1  consumer takes the result.
- `bcd_tens`  out  4  tens digit, 0–6.
- `bcd_ones`  out  4  ones digit, 0–9.
- `busy`  out  1  high in SHIFT and DONE.
- `seg_tens`, `seg_ones`  out  7 each  only when `SEVENSEG_EN` is defined; see Configuration.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On an edge with `in_valid`=1: capture `p` into the shift register, clear the BCD scratch (8 bits), load bit counter = IN_W, go to SHIFT.
- SHIFT:
  - Each edge: for each BCD nibble ≥5, add 3 (both nibbles corrected in parallel, before the shift).
  - Then shift {scratch, binary} left by 1 and decrement the counter.
  - The edge that decrements the counter from 1 to 0 goes to DONE and loads `bcd_tens`/`bcd_ones` from the post-shift scratch.
- DONE:
  - `out_valid`=1; outputs are held stable.
  - On an edge with `out_ready`=1, go to IDLE.
  - `in_ready` stays 0, so there is no same-cycle accept (no bypass).
- Arithmetic:
  - Corrections are 4-bit adds. A carry-out cannot occur for IN_W ≤ 6.
  - The tens nibble never exceeds 6.
- `in_valid` outside IDLE is ignored; `p` is not sampled then.
- `out_ready` outside DONE is ignored.
- Reset (rst_n=0, any state, any time):
  - State goes to IDLE; all registers are cleared.
  - `in_ready`=1 after the reset is released. During reset `in_ready`=0.
  - `out_valid`=0, `busy`=0, `bcd_tens`=`bcd_ones`=0.
  - Segment outputs reset to 7'h3F (displays "0").
  - A conversion in flight when reset arrives is discarded.

## Timing
- Product accepted at edge k.
- SHIFT occupies edges k+1 … k+IN_W.
- `out_valid` rises after edge k+IN_W: 6 cycles for the default IN_W.
- Result consumed at edge m (out_valid & out_ready); `in_ready` is high after edge m.
- Maximum throughput: one conversion per IN_W+2 cycles when `out_ready` is tied high.
- All outputs are registered. `in_ready`, `out_valid` and `busy` are decoded directly from the state register, with no input-to-output combinational path.

## Configuration
- Macro `PRODUCT_BCD_SEVENSEG_EN`.
- Defined:
  - Adds ports `seg_tens[6:0]` and `seg_ones[6:0]`: active-high, bit order gfedcba.
  - Registered and updated on the same edge as the BCD outputs.
  - Encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Reset value 3F on both.
- Undefined: the segment ports and their logic do not exist. All other behaviour is identical.

## Test plan
- Basic conversion: p=49 (7×7), in_valid=1 at edge k, out_ready=1 → out_valid high after edge k+6, tens=4, ones=9, in_ready high after edge k+7.
- Range limits: p=0 → tens=0, ones=0. p=63 → tens=6, ones=3.
- Backpressure: p=9, out_ready=0 for 5 cycles after out_valid.
  - Required: tens=0, ones=9 stable; in_ready=0; busy=1.
  - A p=25 presented with in_valid=1 during this window is ignored.
  - After out_ready=1 for one edge: in_ready=1, and the next accepted p=25 → 2,5.
- Reset in flight: assert rst_n=0 asynchronously mid-SHIFT, after 3 edges with p=36.
  - Required immediately: out_valid=0, busy=0, digits 0.
  - After release: in_ready=1, and p=36 → 3,6 with full 6-cycle latency.
- Exhaustive sweep: all 64 products, plus all nine products from the multiplier bench vectors fed from an instantiated `multiplier` → digits match P/10 and P%10.
- With `PRODUCT_BCD_SEVENSEG_EN` defined: p=49 → seg_tens=66, seg_ones=6F. After reset, both segment outputs = 3F.
